// File: rtl/prio_arbiter8_if.sv
// prio_arbiter8_if: request/grant bundle between requesters and the arbiter
interface prio_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       busy;
  logic       eo;
  logic       timeout;
  modport slave (input en, req, done, output gnt, gnt_id, gnt_valid, busy, eo, timeout);
  modport master(output en, req, done, input gnt, gnt_id, gnt_valid, busy, eo, timeout);
endinterface

// File: rtl/prio_arbiter8.sv
// prio_arbiter8: 8-way priority/round-robin arbiter with registered grant, done handshake and timeout
module prio_arbiter8 #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  prio_arbiter8_if.slave   arb
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t             state_q, state_d;
  logic [7:0]         gnt_q, gnt_d;
  logic [2:0]         id_q, id_d;
  logic [2:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eo_q, eo_d;
  logic               to_q, to_d;
  logic [2:0]         start;
  logic [2:0]         win;
  // winner search: downward from start with wrap; later iterations are closer to start and override
  always_comb begin
    start = (ROUND_ROBIN != 0) ? last_q - 3'd1 : 3'd7;
    win = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (arb.req[start - 3'(k)]) win = start - 3'(k);
  end
  // next state, grant capture, hold counter and status
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    id_d = id_q;
    last_d = last_q;
    cnt_d = cnt_q;
    to_d = 1'b0;
    eo_d = arb.en && state_q == IDLE && arb.req == 8'd0;
    case (state_q)
      IDLE: if (arb.en && arb.req != 8'd0) begin
        state_d = GRANT;
        gnt_d = 8'b1 << win;
        id_d = win;
        cnt_d = '0;
      end
      GRANT: if (arb.done) begin
        state_d = RELEASE;
        gnt_d = 8'd0;
      end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = RELEASE;
        gnt_d = 8'd0;
        to_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      RELEASE: begin
        state_d = IDLE;
        last_d = id_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= 8'd0;
      id_q <= 3'd0;
      last_q <= 3'd0;
      cnt_q <= '0;
      eo_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      eo_q <= eo_d;
      to_q <= to_d;
    end
  assign arb.gnt = gnt_q;
  assign arb.gnt_id = id_q;
  assign arb.gnt_valid = |gnt_q;
  assign arb.busy = state_q != IDLE;
  assign arb.eo = eo_q;
  assign arb.timeout = to_q;
endmodule

// File: tb/tb_prio_arbiter8.sv
// tb_prio_arbiter8: scoreboard bench for a round-robin (TIMEOUT=4) and a fixed-priority (TIMEOUT=3) arbiter
module tb_prio_arbiter8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [7:0] req = 8'd0;
  logic done = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] g;
    logic [2:0] id;
    logic       b;
    logic       eo;
    logic       to;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int owner[2] = '{-1, -1};
  int held[2] = '{0, 0};
  int last[2] = '{0, 0};
  int gid[2] = '{0, 0};
  bit rel[2] = '{0, 0};
  int tmo[2] = '{4, 3};
  bit rr[2] = '{1, 0};
  prio_arbiter8_if if0();
  prio_arbiter8_if if1();
  assign if0.en = en;
  assign if0.req = req;
  assign if0.done = done;
  assign if1.en = en;
  assign if1.req = req;
  assign if1.done = done;
  prio_arbiter8 #(.ROUND_ROBIN(1), .TIMEOUT(4), .CNT_W(8)) u_rr (.clk(clk), .rst(rst), .arb(if0.slave));
  prio_arbiter8 #(.ROUND_ROBIN(0), .TIMEOUT(3), .CNT_W(8)) u_fx (.clk(clk), .rst(rst), .arb(if1.slave));
  always #5 clk = ~clk;
  // first requester found scanning downward from the one below the base, wrapping 0 -> 7
  function automatic int pick(int d, logic [7:0] r);
    int base = rr[d] ? last[d] : 0;
    for (int k = 1; k <= 8; k++)
      if (r[(base - k + 8) % 8]) return (base - k + 8) % 8;
    return -1;
  endfunction
  // advance the reference model by one rising edge and queue the outputs it implies
  task automatic step(int d);
    exp_t e;
    bit eo_n = en && owner[d] < 0 && req == 8'd0;
    bit to_n = 0;
    if (rst) begin
      owner[d] = -1; held[d] = 0; last[d] = 0; gid[d] = 0; rel[d] = 0; eo_n = 0;
    end else if (owner[d] < 0) begin
      if (en && req != 8'd0) begin
        owner[d] = pick(d, req); held[d] = 1; gid[d] = owner[d];
      end
    end else if (rel[d]) begin
      last[d] = owner[d]; owner[d] = -1; rel[d] = 0;
    end else if (done) rel[d] = 1;
    else if (tmo[d] != 0 && held[d] == tmo[d]) begin
      rel[d] = 1; to_n = 1;
    end else held[d]++;
    e.g = (owner[d] >= 0 && !rel[d]) ? 8'(1 << owner[d]) : 8'd0;
    e.id = 3'(gid[d]);
    e.b = owner[d] >= 0;
    e.eo = eo_n;
    e.to = to_n;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask
  task automatic chk(int d, exp_t e, logic [7:0] g, logic [2:0] id, logic v, logic b, logic eo, logic to);
    checks++;
    if (g !== e.g || v !== (|e.g) || b !== e.b || eo !== e.eo || to !== e.to || (e.g != 0 && id !== e.id)) begin
      errors++;
      $display("FAIL dut%0d t=%0t got gnt=%h id=%0d valid=%b busy=%b eo=%b to=%b want gnt=%h id=%0d busy=%b eo=%b to=%b",
               d, $time, g, id, v, b, eo, to, e.g, e.id, e.b, e.eo, e.to);
    end
  endtask
  always @(negedge clk)
    if (q0.size() > 0) chk(0, q0.pop_front(), if0.gnt, if0.gnt_id, if0.gnt_valid, if0.busy, if0.eo, if0.timeout);
  always @(negedge clk)
    if (q1.size() > 0) chk(1, q1.pop_front(), if1.gnt, if1.gnt_id, if1.gnt_valid, if1.busy, if1.eo, if1.timeout);
  task automatic cyc(logic e, logic [7:0] r, logic dn, int n);
    repeat (n) begin
      @(negedge clk);
      en = e; req = r; done = dn;
      @(posedge clk);
      step(0);
      step(1);
    end
  endtask
  task automatic direct_zero(int d, logic [7:0] g, logic [2:0] id, logic v, logic b, logic eo, logic to);
    checks++;
    if ({g, id, v, b, eo, to} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset dut%0d got gnt=%h id=%0d valid=%b busy=%b eo=%b to=%b want all 0", d, g, id, v, b, eo, to);
    end
  endtask
  initial begin
    cyc(0, 8'h00, 0, 2);
    @(negedge clk) rst = 1'b0;
    cyc(1, 8'h81, 0, 3);
    cyc(1, 8'h81, 1, 1);
    cyc(1, 8'h81, 0, 4);
    cyc(1, 8'h81, 1, 1);
    cyc(1, 8'h00, 1, 3);
    repeat (9) begin
      cyc(1, 8'hFF, 0, 1);
      cyc(1, 8'hFF, 1, 1);
      cyc(1, 8'hFF, 0, 1);
    end
    cyc(1, 8'h00, 1, 3);
    cyc(1, 8'h04, 0, 14);
    cyc(1, 8'h00, 1, 3);
    cyc(0, 8'h10, 0, 3);
    cyc(1, 8'h10, 0, 1);
    cyc(0, 8'h10, 0, 2);
    cyc(0, 8'h10, 1, 1);
    cyc(1, 8'h00, 0, 4);
    cyc(1, 8'h00, 1, 3);
    cyc(1, 8'h08, 0, 3);
    cyc(1, 8'h08, 1, 1);
    cyc(1, 8'h00, 0, 3);
    cyc(1, 8'h20, 0, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    direct_zero(0, if0.gnt, if0.gnt_id, if0.gnt_valid, if0.busy, if0.eo, if0.timeout);
    direct_zero(1, if1.gnt, if1.gnt_id, if1.gnt_valid, if1.busy, if1.eo, if1.timeout);
    cyc(1, 8'hFF, 0, 2);
    @(negedge clk) rst = 1'b0;
    cyc(1, 8'hFF, 0, 2);
    cyc(1, 8'hFF, 1, 1);
    repeat (600) begin
      logic [7:0] r = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom) & 8'($urandom);
      cyc($urandom_range(0, 9) != 0, r, $urandom_range(0, 3) == 0, 1);
    end
    cyc(1, 8'h00, 1, 3);
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got q0=%0d q1=%0d pending want 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
